// File: rtl/controla_so_multi_pkg.sv
// Shared types for the BIOS/OS/user mode controller: FSM state encoding,
// modo output codes and exit-cause codes.
package controla_so_pkg;

    typedef enum logic [2:0] {
        BIOS,
        SO,
        RESTAURA,
        USER,
        SALVA,
        HALTED
    } estado_t;

    localparam logic [1:0] MODO_BIOS = 2'd0;
    localparam logic [1:0] MODO_SO   = 2'd1;
    localparam logic [1:0] MODO_USER = 2'd2;
    localparam logic [1:0] MODO_HALT = 2'd3;

    localparam logic CAUSA_FIM     = 1'b0;
    localparam logic CAUSA_PREEMPT = 1'b1;

endpackage

// File: rtl/controla_so_multi_if.sv
// Signal bundle between the mode controller (master) and the CPU / OS /
// context store side (slave).
interface controla_so_multi_if #(
    parameter int N_PROC = 4
) ();
    localparam int PID_W = $clog2(N_PROC);

    logic              HALT;
    logic              os_dispatch;
    logic [PID_W-1:0]  os_pid;
    logic              ctx_ack;
    logic              Sel_BIOS;
    logic              bloq_cpu;
    logic [1:0]        modo;
    logic [PID_W-1:0]  proc_id;
    logic              save_req;
    logic              restore_req;
    logic              causa;
    logic [N_PROC-1:0] proc_fin;
    logic              pid_err;

    modport master (
        input  HALT, os_dispatch, os_pid, ctx_ack,
        output Sel_BIOS, bloq_cpu, modo, proc_id, save_req, restore_req,
               causa, proc_fin, pid_err
    );

    modport slave (
        output HALT, os_dispatch, os_pid, ctx_ack,
        input  Sel_BIOS, bloq_cpu, modo, proc_id, save_req, restore_req,
               causa, proc_fin, pid_err
    );
endinterface

// File: rtl/controla_so_multi_temporizador_quantum.sv
// Time-slice down-counter: reloads to QUANTUM-1 on load, counts down while en,
// and holds at zero (no wrap) with expire asserted.
module temporizador_quantum #(
    parameter int QUANTUM = 1000,
    parameter int QCNT_W  = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam logic [QCNT_W-1:0] RELOAD = QCNT_W'(QUANTUM - 1);

    logic [QCNT_W-1:0] qcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qcnt <= '0;
        end else if (load) begin
            qcnt <= RELOAD;
        end else if (en && (qcnt != '0)) begin
            qcnt <= qcnt - QCNT_W'(1);
        end
    end

    assign expire = (qcnt == '0);
endmodule

// File: rtl/controla_so_multi.sv
// Mode controller: BIOS -> OS kernel -> user processes, sequencing context
// save/restore. Quantum preemption is built only when PREEMPT_EN is defined.
//
// state    | meaning
// BIOS     | fetching from BIOS ROM until the first HALT
// SO       | OS kernel running, waiting for a dispatch or HALT
// RESTAURA | CPU stalled while the context store restores proc_id
// USER     | user process proc_id running
// SALVA    | CPU stalled while the context store saves proc_id
// HALTED   | system halted, terminal until reset
module controla_so_multi
    import controla_so_pkg::*;
#(
    parameter int N_PROC  = 4,
    parameter int QUANTUM = 1000,
    parameter int QCNT_W  = 16
) (
    input logic                 clk,
    input logic                 reset,
    controla_so_multi_if.master bus
);
    localparam int               PID_W      = $clog2(N_PROC);
    localparam logic [PID_W:0]   N_PROC_LIM = (PID_W + 1)'(N_PROC);

    if (N_PROC < 2 || QUANTUM < 2 || $clog2(QUANTUM) > QCNT_W) begin : g_cfg_err
        $error("controla_so_multi: invalid N_PROC/QUANTUM/QCNT_W");
    end

    estado_t           estado_q, estado_d;
    logic              sel_q, sel_d;
    logic              bloq_q, bloq_d;
    logic [1:0]        modo_q, modo_d;
    logic [PID_W-1:0]  pid_q, pid_d;
    logic              save_q, save_d;
    logic              rest_q, rest_d;
    logic              causa_q, causa_d;
    logic [N_PROC-1:0] fin_q, fin_d;
    logic              err_q, err_d;
    logic              expire;

`ifdef PREEMPT_EN
    logic timer_load;
    logic timer_en;

    // Reload exactly on the edge that enters USER.
    assign timer_load = (estado_q == RESTAURA) && bus.ctx_ack;
    assign timer_en   = (estado_q == USER);

    temporizador_quantum #(
        .QUANTUM (QUANTUM),
        .QCNT_W  (QCNT_W)
    ) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .en     (timer_en),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= BIOS;
            sel_q    <= 1'b1;
            bloq_q   <= 1'b0;
            modo_q   <= MODO_BIOS;
            pid_q    <= '0;
            save_q   <= 1'b0;
            rest_q   <= 1'b0;
            causa_q  <= CAUSA_FIM;
            fin_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            sel_q    <= sel_d;
            bloq_q   <= bloq_d;
            modo_q   <= modo_d;
            pid_q    <= pid_d;
            save_q   <= save_d;
            rest_q   <= rest_d;
            causa_q  <= causa_d;
            fin_q    <= fin_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        sel_d    = sel_q;
        bloq_d   = bloq_q;
        modo_d   = modo_q;
        pid_d    = pid_q;
        save_d   = save_q;
        rest_d   = rest_q;
        causa_d  = causa_q;
        fin_d    = fin_q;
        err_d    = err_q;

        case (estado_q)
            BIOS: begin
                if (bus.HALT) begin
                    estado_d = SO;
                    sel_d    = 1'b0;
                    modo_d   = MODO_SO;
                end
            end
            SO: begin
                if (bus.HALT) begin
                    estado_d = HALTED;
                    bloq_d   = 1'b1;
                    modo_d   = MODO_HALT;
                end else if (bus.os_dispatch) begin
                    if ({1'b0, bus.os_pid} < N_PROC_LIM) begin
                        estado_d             = RESTAURA;
                        pid_d                = bus.os_pid;
                        rest_d               = 1'b1;
                        bloq_d               = 1'b1;
                        fin_d[bus.os_pid]    = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RESTAURA: begin
                if (bus.ctx_ack) begin
                    estado_d = USER;
                    rest_d   = 1'b0;
                    bloq_d   = 1'b0;
                    modo_d   = MODO_USER;
                end
            end
            USER: begin
                // HALT takes priority over a same-cycle quantum expiry.
                if (bus.HALT || expire) begin
                    estado_d = SALVA;
                    save_d   = 1'b1;
                    bloq_d   = 1'b1;
                    causa_d  = bus.HALT ? CAUSA_FIM : CAUSA_PREEMPT;
                    if (bus.HALT) begin
                        fin_d[pid_q] = 1'b1;
                    end
                end
            end
            SALVA: begin
                if (bus.ctx_ack) begin
                    estado_d = SO;
                    save_d   = 1'b0;
                    bloq_d   = 1'b0;
                    modo_d   = MODO_SO;
                end
            end
            HALTED: begin
            end
            default: begin
                estado_d = BIOS;
            end
        endcase
    end

    assign bus.Sel_BIOS    = sel_q;
    assign bus.bloq_cpu    = bloq_q;
    assign bus.modo        = modo_q;
    assign bus.proc_id     = pid_q;
    assign bus.save_req    = save_q;
    assign bus.restore_req = rest_q;
    assign bus.causa       = causa_q;
    assign bus.proc_fin    = fin_q;
    assign bus.pid_err     = err_q;
endmodule
